// File: rtl/mem_word_initiator_pkg.sv
// Shared encodings for the byte-serial memory initiator: access sizes, FSM states,
// default busy timeout and small request-decoding helpers.
package mem_word_initiator_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'd0;
    localparam logic [1:0] SIZE_HALF    = 2'd1;
    localparam logic [1:0] SIZE_WORD    = 2'd2;
    localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Index of the final beat: 0, 1 or 3 for byte, halfword, word.
    function automatic logic [1:0] last_beat(input logic [1:0] size);
        logic [1:0] idx;
        idx = 2'd3;
        case (size)
            SIZE_BYTE: idx = 2'd0;
            SIZE_HALF: idx = 2'd1;
            default:   idx = 2'd3;
        endcase
        return idx;
    endfunction

    function automatic logic req_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lo[0];
            SIZE_WORD: bad = (addr_lo != 2'd0);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Left-justify the store data so the first (most significant) beat sits in [31:24].
    function automatic logic [31:0] align_store(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        d = wdata;
        case (size)
            SIZE_BYTE: d = {wdata[7:0], 24'h0};
            SIZE_HALF: d = {wdata[15:0], 16'h0};
            default:   d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_word_initiator.sv
// Splits CPU byte/half/word accesses into big-endian byte beats on an 8-bit RAM port.
// Latency: 1 + 2*beats cycles from acceptance without stalls; errors respond next cycle.
// Backpressure: one transaction in flight, req_ready only in IDLE; ram_busy stretches WAIT.
module mem_word_initiator
    import mem_word_initiator_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [1:0]               req_size,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [31:0]              req_wdata,
    output logic                     resp_valid,
    output logic [31:0]              resp_rdata,
    output logic                     resp_err,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [7:0]               ram_wdata,
    output logic                     ram_we,
    input  logic [7:0]               ram_rdata,
    input  logic                     ram_busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t                   state_q, state_d;
    logic                     write_q;
    logic                     err_q;
    logic [1:0]               last_q;
    logic [1:0]               beat_idx_q;
    logic [TW-1:0]            tcount_q;
    logic [ADDRESS_WIDTH-1:0] base_q;
    logic [ADDRESS_WIDTH-1:0] ram_addr_q;
    logic [7:0]               ram_wdata_q;
    logic [31:0]              sdata_q;
    logic [31:0]              result_q;

    logic        accept, illegal, beat_done, is_last, timed_out;
    logic [31:0] aligned;
    logic [ADDRESS_WIDTH-1:0] next_addr;

    assign accept    = (state_q == IDLE) && req_valid;
    assign illegal   = req_illegal(req_size, req_addr[1:0]);
    assign aligned   = align_store(req_size, req_wdata);
    assign beat_done = (state_q == WAIT) && !ram_busy;
    assign is_last   = (beat_idx_q == last_q);
    assign timed_out = (state_q == WAIT) && ram_busy && (tcount_q == TIMEOUT_LAST);
    assign next_addr = base_q + ADDRESS_WIDTH'(beat_idx_q + 2'd1);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (req_valid) state_d = illegal ? RESP : ISSUE;
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (beat_done)      state_d = is_last ? RESP : ISSUE;
                else if (timed_out) state_d = RESP;
            end
            RESP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        resp_err   = resp_valid && err_q;
        resp_rdata = (resp_valid && !err_q) ? result_q : 32'h0;
        ram_we     = (state_q == ISSUE) && write_q;
        ram_addr   = ram_addr_q;
        ram_wdata  = ram_wdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_q     <= 1'b0;
            err_q       <= 1'b0;
            last_q      <= 2'd0;
            beat_idx_q  <= 2'd0;
            tcount_q    <= '0;
            base_q      <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= 8'h0;
            sdata_q     <= 32'h0;
            result_q    <= 32'h0;
        end else if (accept) begin
            write_q    <= req_write;
            base_q     <= req_addr;
            last_q     <= last_beat(req_size);
            err_q      <= illegal;
            result_q   <= 32'h0;
            beat_idx_q <= 2'd0;
            tcount_q   <= '0;
            // Rejected requests leave the RAM port untouched.
            if (!illegal) begin
                ram_addr_q <= req_addr;
                if (req_write) begin
                    ram_wdata_q <= aligned[31:24];
                    sdata_q     <= {aligned[23:0], 8'h0};
                end
            end
        end else if (beat_done) begin
            tcount_q <= '0;
            if (!write_q) result_q <= {result_q[23:0], ram_rdata};
            if (!is_last) begin
                beat_idx_q <= beat_idx_q + 2'd1;
                ram_addr_q <= next_addr;
                if (write_q) begin
                    ram_wdata_q <= sdata_q[31:24];
                    sdata_q     <= {sdata_q[23:0], 8'h0};
                end
            end
        end else if ((state_q == WAIT) && ram_busy) begin
            tcount_q <= tcount_q + TW'(1);
            if (timed_out) begin
                err_q    <= 1'b1;
                result_q <= 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_mem_word_initiator.sv
// Scoreboard bench: directed requests push expected responses; a negedge monitor
// pops and compares data, error flag and completion cycle against a byte-RAM model.
module tb_mem_word_initiator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata;
    logic        ram_busy = 1'b0;

    mem_word_initiator #(.ADDRESS_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .ram_busy(ram_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Byte RAM model: registered read, data garbage while busy.
    logic [7:0] mem [0:255];
    logic [7:0] rdata_q = 8'h0;
    logic       mem_clr = 1'b1;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h0;
        end else if (ram_we) begin
            mem[ram_addr[7:0]] <= ram_wdata;
        end
        rdata_q <= mem[ram_addr[7:0]];
    end
    assign ram_rdata = ram_busy ? 8'h5A : rdata_q;

    int busy_lo = 1;
    int busy_hi = 0;
    always @(negedge clk) ram_busy = (cyc >= busy_lo) && (cyc <= busy_hi);

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;
    exp_t q[$];

    int total = 0;
    int bad = 0;
    int coincide = 0;
    int idle_dirty = 0;
    int we_count = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (ram_we) we_count++;
            if (resp_valid && req_ready) coincide++;
            if (!resp_valid && (resp_rdata != 32'h0 || resp_err)) idle_dirty++;
            if (resp_valid) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_resp: got rdata=%h err=%0d at cyc %0d, want no response",
                             resp_rdata, resp_err, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (resp_rdata !== e.rdata || resp_err !== e.err || cyc != e.due) begin
                        bad++;
                        $display("FAIL %s: got rdata=%h err=%0d cyc=%0d, want rdata=%h err=%0d cyc=%0d",
                                 e.name, resp_rdata, resp_err, cyc, e.rdata, e.err, e.due);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Called at a negedge; drives one request and returns its acceptance cycle.
    task automatic issue(input string name, input logic w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] er, input logic ee, input int lat,
                         input bit expect_resp, input int blo, input int bhi, output int t);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL %s_ready: got req_ready=0 want 1", name);
        end
        req_write = w;
        req_size  = sz;
        req_addr  = a;
        req_wdata = wd;
        req_valid = 1'b1;
        t = cyc;
        if (blo >= 0) begin
            busy_lo = t + blo;
            busy_hi = t + bhi;
        end
        if (expect_resp) q.push_back('{name, er, ee, t + lat});
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = 32'h0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            total++;
            bad += q.size();
            $display("FAIL %s_timeout: got %0d pending responses want 0", name, q.size());
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int we0;
        logic [31:0] addr0;

        repeat (3) @(negedge clk);
        mem_clr = 1'b0;
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", 32'(resp_err), 32'h0);
        chk("rst_ram_addr", ram_addr, 32'h0);
        chk("rst_ram_wdata", 32'(ram_wdata), 32'h0);
        chk("rst_ram_we", 32'(ram_we), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        issue("st_word_10", 1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 9, 1'b1, -1, 0, t);
        drain("st_word_10");
        chk("mem_10", 32'(mem[8'h10]), 32'hDE);
        chk("mem_11", 32'(mem[8'h11]), 32'hAD);
        chk("mem_12", 32'(mem[8'h12]), 32'hBE);
        chk("mem_13", 32'(mem[8'h13]), 32'hEF);

        issue("ld_word_10", 1'b0, 2'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 9, 1'b1, -1, 0, t);
        drain("ld_word_10");
        issue("ld_byte_12", 1'b0, 2'd0, 32'h12, 32'h0, 32'h000000BE, 1'b0, 3, 1'b1, -1, 0, t);
        drain("ld_byte_12");
        issue("ld_half_12", 1'b0, 2'd1, 32'h12, 32'h0, 32'h0000BEEF, 1'b0, 5, 1'b1, -1, 0, t);
        drain("ld_half_12");

        we0 = we_count;
        addr0 = ram_addr;
        chk("addr_before_misalign", addr0, 32'h13);
        issue("ld_half_11", 1'b0, 2'd1, 32'h11, 32'h0, 32'h0, 1'b1, 1, 1'b1, -1, 0, t);
        drain("ld_half_11");
        issue("ld_word_12", 1'b0, 2'd2, 32'h12, 32'h0, 32'h0, 1'b1, 1, 1'b1, -1, 0, t);
        drain("ld_word_12");
        issue("st_illegal", 1'b1, 2'd3, 32'h10, 32'h12345678, 32'h0, 1'b1, 1, 1'b1, -1, 0, t);
        drain("st_illegal");
        chk("misalign_no_we", 32'(we_count - we0), 32'h0);
        chk("misalign_addr_held", ram_addr, addr0);
        chk("misalign_mem_10", 32'(mem[8'h10]), 32'hDE);

        issue("ld_word_busy3", 1'b0, 2'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 12, 1'b1, 4, 6, t);
        drain("ld_word_busy3");
        issue("ld_word_tmo", 1'b0, 2'd2, 32'h10, 32'h0, 32'h0, 1'b1, 18, 1'b1, 2, 17, t);
        drain("ld_word_tmo");

        issue("st_half_30", 1'b1, 2'd1, 32'h30, 32'h0000CAFE, 32'h0, 1'b0, 5, 1'b1, -1, 0, t);
        drain("st_half_30");
        issue("st_byte_32", 1'b1, 2'd0, 32'h32, 32'hFFFFFF77, 32'h0, 1'b0, 3, 1'b1, -1, 0, t);
        drain("st_byte_32");
        chk("mem_30", 32'(mem[8'h30]), 32'hCA);
        chk("mem_31", 32'(mem[8'h31]), 32'hFE);
        issue("ld_word_30", 1'b0, 2'd2, 32'h30, 32'h0, 32'hCAFE7700, 1'b0, 9, 1'b1, -1, 0, t);
        drain("ld_word_30");

        // Reset lands in the WAIT of the second beat of a word store.
        issue("st_word_20", 1'b1, 2'd2, 32'h20, 32'h11223344, 32'h0, 1'b0, 9, 1'b0, -1, 0, t);
        while (cyc < t + 4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_req_ready", 32'(req_ready), 32'h1);
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("mid_rst_ram_addr", ram_addr, 32'h0);
        chk("mid_rst_ram_wdata", 32'(ram_wdata), 32'h0);
        chk("mid_rst_ram_we", 32'(ram_we), 32'h0);
        reset = 1'b0;
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        issue("ld_byte_20", 1'b0, 2'd0, 32'h20, 32'h0, 32'h00000011, 1'b0, 3, 1'b1, -1, 0, t);
        drain("ld_byte_20");
        chk("mem_20", 32'(mem[8'h20]), 32'h11);
        chk("mem_21", 32'(mem[8'h21]), 32'h22);
        chk("mem_22", 32'(mem[8'h22]), 32'h00);
        chk("mem_23", 32'(mem[8'h23]), 32'h00);

        repeat (3) @(negedge clk);
        chk("resp_ready_overlap", 32'(coincide), 32'h0);
        chk("idle_outputs_zero", 32'(idle_dirty), 32'h0);
        chk("scoreboard_empty", 32'(q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_word_initiator.md
MEM_WORD_INITIATOR -- requirements
Module: mem_word_initiator

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32: width of req_addr and ram_addr.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum consecutive busy cycles per beat before abort.
REQ-003 clk  input  1  clock; all state changes on posedge clk.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  CPU request present.
REQ-006 req_ready  output  1  initiator accepts a request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal.
REQ-009 req_addr  input  ADDRESS_WIDTH  byte address of the access.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  load data, right-aligned, zero-extended.
REQ-013 resp_err  output  1  qualifies resp_valid: misaligned, illegal size or timeout.
REQ-014 ram_addr  output  ADDRESS_WIDTH  byte address to the 8-bit RAM port A.
REQ-015 ram_wdata  output  8  byte to write.
REQ-016 ram_we  output  1  RAM write enable.
REQ-017 ram_rdata  input  8  RAM port A read data.
REQ-018 ram_busy  input  1  RAM port A busy; data invalid while high.

Function
REQ-019 SHALL use FSM states IDLE, ISSUE, WAIT, RESP.
REQ-020 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid && req_ready, and all request fields are registered at acceptance.
REQ-021 Beat count SHALL be 1/2/4 for byte/halfword/word; beats are issued at addresses base+0 ... base+N-1.
REQ-022 Byte order SHALL be big-endian: beat 0 carries the most significant byte of the access.
REQ-023 Misalignment (halfword addr[0]=1; word addr[1:0]!=0) or req_size=3 SHALL skip all RAM activity: IDLE->RESP, resp_valid=1 and resp_err=1 in the cycle after acceptance, with resp_rdata=0.
REQ-024 IDLE->ISSUE on a legal acceptance.
REQ-025 ISSUE SHALL hold one cycle: drive ram_addr with the beat address; for stores, ram_we=1 and ram_wdata=beat byte. Then go to WAIT.
REQ-026 In WAIT, ram_we SHALL be 0 and ram_addr held.
REQ-027 In WAIT with ram_busy=0: on loads, ram_rdata is shifted into the result; then the next beat goes to ISSUE, or the last beat goes to RESP.
REQ-028 In WAIT with ram_busy=1, a per-beat counter SHALL increment; when it reaches TIMEOUT_CYCLES the FSM SHALL go to RESP with resp_err=1 and resp_rdata=0, with no further beats issued.
REQ-029 RESP SHALL assert resp_valid for exactly one cycle, then return to IDLE; resp_valid=1 and req_ready=1 SHALL never coincide.
REQ-030 No-stall latency from acceptance cycle T SHALL be: byte resp at T+3, halfword at T+5, word at T+9.
REQ-031 Store responses SHALL have resp_rdata=0.
REQ-032 ram_addr SHALL hold its last value outside ISSUE/WAIT, so the RAM is not disturbed by address changes while idle.
REQ-033 resp_rdata and resp_err SHALL be valid only while resp_valid=1 and SHALL be 0 otherwise.

Reset
REQ-034 reset SHALL force IDLE and set req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, ram_addr=0, ram_wdata=0, ram_we=0, and clear the beat and timeout counters.
REQ-035 Reset during ISSUE/WAIT/RESP SHALL abandon the transaction with no response pulse; req_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-036 A shared package SHALL hold the req_size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD), the FSM state enum and the default TIMEOUT_CYCLES.
REQ-037 The block SHALL be a single module with no sub-modules; it connects directly to SimpleRam port A (addrA, dataIn, writeEnable, outA, busyA).

Verification
REQ-038 Word store 0xDEADBEEF at 0x10, then word load at 0x10 -> RAM bytes 0x10..0x13 = DE AD BE EF; load resp_rdata=0xDEADBEEF, resp_err=0, resp_valid at T+9.
REQ-039 Byte load at 0x12 after REQ-038 -> resp_rdata=0x000000BE at T+3; halfword load at 0x12 -> 0x0000BEEF at T+5.
REQ-040 Halfword load at 0x11 and word load at 0x12 -> resp_err=1, resp_rdata=0 at T+1, ram_we never asserted, ram_addr unchanged.
REQ-041 ram_busy held high 3 cycles on beat 1 of a word load -> completion delayed exactly 3 cycles (T+12) with correct data; ram_busy held high permanently -> resp_err=1 after 16 WAIT cycles.
REQ-042 reset asserted in WAIT of beat 2 of a word store -> no resp_valid, outputs at reset values, only bytes 0..1 written; a new request is accepted in the first cycle after reset deasserts.
